// File: rtl/pc_fetch_ctrl.sv
// PC sequencing and instruction-fetch handshake controller for the MIPS core.
// Optional macro PC_FETCH_PERF_EN adds fetch_cnt / squash_cnt performance counters.
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_q,
  output logic        pc_ena,
  output logic [31:0] pc_next,
  output logic        if_req,
  output logic [31:0] if_addr,
  input  logic        if_ack,
  output logic        if_squash,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_type,
  input  logic [31:0] redir_pc,
  input  logic [15:0] redir_imm16,
  input  logic [25:0] redir_index,
  input  logic [31:0] redir_reg,
  output logic        addr_err
`ifdef PC_FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] squash_cnt
`endif
);

  typedef enum logic [1:0] {ST_BOOT, ST_REQ, ST_WAIT, ST_UPD} state_t;

  localparam logic [1:0] RT_BRANCH = 2'b00;
  localparam logic [1:0] RT_JUMP   = 2'b01;
  localparam logic [1:0] RT_JR     = 2'b10;
  localparam logic [1:0] RT_EXC    = 2'b11;

  state_t      r_state, w_state_next;
  logic        r_pc_ena, w_pc_ena_next;
  logic [31:0] r_pc_load, w_pc_load_next;
  logic        r_pending;
  logic        r_pend_exc;
  logic [31:0] r_pend_target;

  logic [31:0] w_redir_pc4;
  logic [31:0] w_br_target;
  logic [31:0] w_j_target;
  logic [31:0] w_raw_target;
  logic        w_jr_misalign;
  logic [31:0] w_new_target;
  logic        w_new_exc;
  logic        w_accept;
  logic        w_sel_valid;
  logic [31:0] w_sel_target;
  logic        w_sel_exc;
  logic [31:0] w_pc_seq;
  logic        w_consume;

  assign w_redir_pc4 = redir_pc + 32'd4;
  assign w_br_target = w_redir_pc4 + {{14{redir_imm16[15]}}, redir_imm16, 2'b00};
  assign w_j_target  = {w_redir_pc4[31:28], redir_index, 2'b00};

  always_comb begin
    w_raw_target = EXC_VECTOR;
    unique case (redirect_type)
      RT_BRANCH: w_raw_target = w_br_target;
      RT_JUMP:   w_raw_target = w_j_target;
      RT_JR:     w_raw_target = redir_reg;
      RT_EXC:    w_raw_target = EXC_VECTOR;
      default:   w_raw_target = EXC_VECTOR;
    endcase
  end

  // A misaligned jr target is turned into an exception so it also gains exception priority.
  assign w_jr_misalign = (redirect_type == RT_JR) && (redir_reg[1:0] != 2'b00);
  assign w_new_target  = w_jr_misalign ? EXC_VECTOR : w_raw_target;
  assign w_new_exc     = (redirect_type == RT_EXC) || w_jr_misalign;
  assign w_accept      = redirect_valid && (r_state != ST_BOOT) && (!r_pend_exc || w_new_exc);
  assign addr_err      = w_accept && w_jr_misalign;

  // Merged view of the held redirect and one arriving this cycle.
  assign w_sel_valid  = w_accept || r_pending;
  assign w_sel_target = w_accept ? w_new_target : r_pend_target;
  assign w_sel_exc    = w_accept ? w_new_exc : r_pend_exc;

  assign w_pc_seq = pc_q + 32'd4;
  assign if_addr  = pc_q;
  assign pc_ena   = r_pc_ena;
  assign pc_next  = r_pc_load;

  always_comb begin
    w_state_next   = r_state;
    w_pc_ena_next  = 1'b0;
    w_pc_load_next = r_pc_load;
    w_consume      = 1'b0;
    if_req         = 1'b0;
    if_squash      = 1'b0;
    unique case (r_state)
      ST_BOOT: begin
        w_state_next   = ST_UPD;
        w_pc_ena_next  = 1'b1;
        w_pc_load_next = RESET_PC;
      end
      ST_REQ: begin
        if_req = !stall && !w_sel_valid;
        if (w_sel_valid) begin
          w_state_next   = ST_UPD;
          w_pc_ena_next  = 1'b1;
          w_pc_load_next = w_sel_target;
          w_consume      = 1'b1;
        end else if (!stall) begin
          w_state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if_req = 1'b1;
        if (if_ack) begin
          if_squash      = w_sel_valid;
          w_state_next   = ST_UPD;
          w_pc_ena_next  = 1'b1;
          w_pc_load_next = w_sel_valid ? w_sel_target : w_pc_seq;
          w_consume      = w_sel_valid;
        end
      end
      ST_UPD: begin
        w_state_next = ST_REQ;
      end
      default: begin
        w_state_next = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_BOOT;
      r_pc_ena  <= 1'b0;
      r_pc_load <= RESET_PC;
    end else begin
      r_state   <= w_state_next;
      r_pc_ena  <= w_pc_ena_next;
      r_pc_load <= w_pc_load_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending     <= 1'b0;
      r_pend_exc    <= 1'b0;
      r_pend_target <= 32'h0000_0000;
    end else if (w_consume) begin
      r_pending  <= 1'b0;
      r_pend_exc <= 1'b0;
    end else if (w_accept) begin
      r_pending     <= 1'b1;
      r_pend_exc    <= w_sel_exc;
      r_pend_target <= w_sel_target;
    end
  end

`ifdef PC_FETCH_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_squash_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_cnt  <= 32'd0;
      r_squash_cnt <= 32'd0;
    end else begin
      if ((r_state == ST_WAIT) && if_ack) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (if_squash) begin
        r_squash_cnt <= r_squash_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt  = r_fetch_cnt;
  assign squash_cnt = r_squash_cnt;
`endif

endmodule
